// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control FSM for the RV64 subset datapath
// (add, sub, and, or, ld, sd, beq). Decodes the instruction register fields,
// sequences FETCH/DECODE/execute/writeback states and drives the per-cycle
// datapath strobes, including the ALU operation code and operand selects,
// plus a valid/ready handshake to a shared instruction/data memory.
//
// Optional feature: define MULTICYCLE_CONTROL_BNE_EN to also accept bne
// (opcode 1100011, funct3 001); otherwise that encoding traps.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   opcode/funct3/funct7_5  instruction register fields
//   alu_zero            ALU result is zero (branch compare)
//   mem_ready           memory completed the current request
//   aluControl          ALU op: 0010 add, 0110 sub, 0000 and, 0001 or
//   alu_src_a/alu_src_b ALU operand selects
//   pc_write, pc_write_target  PC load from ALU result / ALUOut
//   ir_write, aluout_write     instruction register / ALUOut load enables
//   mem_req, mem_we, mem_addr_sel  memory request, direction, address source
//   reg_write, mem_to_reg      register-file write enable and source
//   illegal             sticky flag: undecodable instruction or memory timeout
//   state               current state encoding (debug)

module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] aluControl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic       pc_write_target,
    output logic       ir_write,
    output logic       aluout_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd15
    } state_t;

    state_t             state_q;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               illegal_q;

    logic               is_ld;
    logic               is_sd;
    logic               is_rtype;
    logic               is_branch;
    logic               mem_phase;
    logic               waiting;
    logic               timeout_hit;

    // Instruction class decode from the instruction register fields
    always_comb begin
        is_ld     = (opcode == OP_LOAD)  && (funct3 == 3'b011);
        is_sd     = (opcode == OP_STORE) && (funct3 == 3'b011);
        is_rtype  = (opcode == OP_RTYPE) &&
                    ((funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110));
`ifdef MULTICYCLE_CONTROL_BNE_EN
        is_branch = (opcode == OP_BRANCH) && ((funct3 == 3'b000) || (funct3 == 3'b001));
`else
        is_branch = (opcode == OP_BRANCH) && (funct3 == 3'b000);
`endif
    end

    // States that hold a memory request open; only these count wait cycles
    always_comb begin
        mem_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        waiting   = mem_phase && !mem_ready;
        // Trap at the end of the MEM_TIMEOUT-th consecutive wait cycle; a
        // mem_ready in that cycle means it is not a wait cycle, so no trap.
        timeout_hit = (MEM_TIMEOUT != 0) && waiting &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Wait counter: counts stalled request cycles, clears on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!waiting) begin
            wait_cnt <= '0;
        end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Sticky illegal flag, set on entry to TRAP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_next == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (is_ld || is_sd) begin
                    state_next = S_MEM_ADDR;
                end else if (is_rtype) begin
                    state_next = S_EXEC;
                end else if (is_branch) begin
                    state_next = S_BRANCH;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEM_ADDR: begin
                state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_MEM_WB: state_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC:   state_next = S_ALU_WB;
            S_ALU_WB: state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    // Moore strobes decoded from state (plus mem_ready/alu_zero where needed)
    always_comb begin
        aluControl      = ALU_ADD;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_write        = 1'b0;
        pc_write_target = 1'b0;
        ir_write        = 1'b0;
        aluout_write    = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr_sel    = 1'b0;
        reg_write       = 1'b0;
        mem_to_reg      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // Latch the instruction and advance PC by 4
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
            end
            S_DECODE: begin
                // Precompute the branch target PC+imm into ALUOut
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_EXEC: begin
                alu_src_a    = 1'b1;
                aluout_write = 1'b1;
                case (funct3)
                    3'b000:  aluControl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  aluControl = ALU_AND;
                    3'b110:  aluControl = ALU_OR;
                    default: aluControl = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                aluControl = ALU_SUB;
`ifdef MULTICYCLE_CONTROL_BNE_EN
                pc_write_target = (funct3 == 3'b001) ? !alu_zero : alu_zero;
`else
                pc_write_target = alu_zero;
`endif
            end
            default: begin
            end
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int unsigned TMO = 4;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_AND = 32'h0020F1B3;
    localparam logic [31:0] I_OR  = 32'h0020E1B3;
    localparam logic [31:0] I_LD  = 32'h0000B183;
    localparam logic [31:0] I_SD  = 32'h0030B023;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_BNE = 32'h00209463;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       alu_zero;
    logic       mem_ready;
    logic [3:0] aluControl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_target;
    logic       ir_write;
    logic       aluout_write;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7_5        (funct7_5),
        .alu_zero        (alu_zero),
        .mem_ready       (mem_ready),
        .aluControl      (aluControl),
        .alu_src_a       (alu_src_a),
        .alu_src_b       (alu_src_b),
        .pc_write        (pc_write),
        .pc_write_target (pc_write_target),
        .ir_write        (ir_write),
        .aluout_write    (aluout_write),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr_sel    (mem_addr_sel),
        .reg_write       (reg_write),
        .mem_to_reg      (mem_to_reg),
        .illegal         (illegal),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [31:0] instr);
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7_5 = instr[30];
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // From FETCH with zero wait states, through DECODE, to the next state
    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        #1;
        check({tag, "_fetch_state"}, 32'(state), 32'd0);
        check({tag, "_ir_write"}, 32'(ir_write), 32'd1);
        check({tag, "_pc_write"}, 32'(pc_write), 32'd1);
        check({tag, "_fetch_srcb"}, 32'(alu_src_b), 32'd1);
        step();
        check({tag, "_dec_state"}, 32'(state), 32'd1);
        check({tag, "_dec_aluout"}, 32'(aluout_write), 32'd1);
        check({tag, "_dec_srcb"}, 32'(alu_src_b), 32'd2);
        step();
    endtask

    task automatic run_rtype(input string tag, input logic [31:0] instr, input logic [3:0] alu);
        set_instr(instr);
        fetch_decode(tag);
        check({tag, "_exec_state"}, 32'(state), 32'd6);
        check({tag, "_exec_alu"}, 32'(aluControl), 32'(alu));
        check({tag, "_exec_srca"}, 32'(alu_src_a), 32'd1);
        check({tag, "_exec_srcb"}, 32'(alu_src_b), 32'd0);
        check({tag, "_exec_regw"}, 32'(reg_write), 32'd0);
        step();
        check({tag, "_wb_state"}, 32'(state), 32'd7);
        check({tag, "_wb_regw"}, 32'(reg_write), 32'd1);
        check({tag, "_wb_m2r"}, 32'(mem_to_reg), 32'd0);
        step();
        check({tag, "_done_state"}, 32'(state), 32'd0);
        check({tag, "_done_regw"}, 32'(reg_write), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        set_instr(I_LD);
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // Reset asserted mid-load while stalled in MEM_RD
        rst_n = 1'b1;
        fetch_decode("ld0");
        check("ld0_addr_state", 32'(state), 32'd2);
        mem_ready = 1'b0;
        step();
        check("ld0_rd_state", 32'(state), 32'd3);
        step();
        check("ld0_rd_hold", 32'(state), 32'd3);
        do_reset();
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_memreq", 32'(mem_req), 32'd1);
        check("midrst_addrsel", 32'(mem_addr_sel), 32'd0);
        check("midrst_illegal", 32'(illegal), 32'd0);

        run_rtype("add", I_ADD, 4'b0010);
        run_rtype("sub", I_SUB, 4'b0110);
        run_rtype("and", I_AND, 4'b0000);
        run_rtype("or",  I_OR,  4'b0001);

        // ld with three wait states in MEM_RD
        set_instr(I_LD);
        fetch_decode("ld");
        check("ld_addr_state", 32'(state), 32'd2);
        check("ld_addr_srca", 32'(alu_src_a), 32'd1);
        check("ld_addr_srcb", 32'(alu_src_b), 32'd2);
        check("ld_addr_aluout", 32'(aluout_write), 32'd1);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("ld_rd_state", 32'(state), 32'd3);
            check("ld_rd_req", 32'(mem_req), 32'd1);
            check("ld_rd_we", 32'(mem_we), 32'd0);
            check("ld_rd_addrsel", 32'(mem_addr_sel), 32'd1);
            step();
        end
        check("ld_wb_state", 32'(state), 32'd4);
        check("ld_wb_regw", 32'(reg_write), 32'd1);
        check("ld_wb_m2r", 32'(mem_to_reg), 32'd1);
        step();
        check("ld_done_state", 32'(state), 32'd0);

        // sd, zero wait states
        set_instr(I_SD);
        fetch_decode("sd");
        check("sd_addr_state", 32'(state), 32'd2);
        step();
        check("sd_wr_state", 32'(state), 32'd5);
        check("sd_wr_req", 32'(mem_req), 32'd1);
        check("sd_wr_we", 32'(mem_we), 32'd1);
        check("sd_wr_addrsel", 32'(mem_addr_sel), 32'd1);
        check("sd_wr_regw", 32'(reg_write), 32'd0);
        step();
        check("sd_done_state", 32'(state), 32'd0);

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            set_instr(I_BEQ);
            alu_zero = (z == 1);
            fetch_decode("beq");
            check("beq_state", 32'(state), 32'd8);
            check("beq_alu", 32'(aluControl), 32'd6);
            check("beq_srca", 32'(alu_src_a), 32'd1);
            check("beq_pct", 32'(pc_write_target), 32'(z));
            check("beq_pcw", 32'(pc_write), 32'd0);
            step();
            check("beq_done_state", 32'(state), 32'd0);
        end

        // Undecodable opcode traps; illegal persists
        set_instr(I_BAD);
        fetch_decode("bad");
        check("bad_state", 32'(state), 32'd15);
        check("bad_illegal", 32'(illegal), 32'd1);
        check("bad_memreq", 32'(mem_req), 32'd0);
        check("bad_aluout", 32'(aluout_write), 32'd0);
        step();
        step();
        check("bad_hold_state", 32'(state), 32'd15);
        check("bad_hold_illegal", 32'(illegal), 32'd1);
        do_reset();
        check("bad_rst_illegal", 32'(illegal), 32'd0);

        // bne: branch when the option is built in, trap otherwise
        set_instr(I_BNE);
        alu_zero = 1'b0;
        fetch_decode("bne");
`ifdef MULTICYCLE_CONTROL_BNE_EN
        check("bne_state", 32'(state), 32'd8);
        check("bne_pct", 32'(pc_write_target), 32'd1);
`else
        check("bne_state", 32'(state), 32'd15);
        check("bne_illegal", 32'(illegal), 32'd1);
`endif
        do_reset();

        // Fetch timeout: TMO consecutive wait cycles then TRAP
        set_instr(I_ADD);
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < int'(TMO); i++) begin
            check("tmo_wait_state", 32'(state), 32'd0);
            check("tmo_wait_req", 32'(mem_req), 32'd1);
            step();
        end
        check("tmo_state", 32'(state), 32'd15);
        check("tmo_illegal", 32'(illegal), 32'd1);
        do_reset();

        // mem_ready in the last allowed cycle completes without trap
        mem_ready = 1'b0;
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("tmo_edge_state", 32'(state), 32'd0);
        check("tmo_edge_irw", 32'(ir_write), 32'd1);
        step();
        check("tmo_edge_next", 32'(state), 32'd1);
        check("tmo_edge_illegal", 32'(illegal), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
